// File: rtl/io_handshake_controller_pkg.sv
// Shared definitions for the push-button handshake sequencer: FSM encodings,
// the default debounce length and a small edge-detect helper.
package io_handshake_controller_pkg;

  typedef enum logic [1:0] {
    IO_IDLE    = 2'd0,
    IO_ARMED   = 2'd1,
    IO_FIRE    = 2'd2,
    IO_RELEASE = 2'd3
  } io_state_e;

  // 10 ms at 50 MHz
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

  function automatic logic rising(input logic now_level, input logic prev_level);
    return now_level & ~prev_level;
  endfunction

endpackage

// File: rtl/io_handshake_controller_button_debouncer.sv
// Two-flop synchronizer followed by a stable-level debouncer: a level change is
// accepted only after DEBOUNCE_CYCLES consecutive differing synchronized samples.
module button_debouncer
  import io_handshake_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_WIDTH       = 19
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync1_r;
  logic                 sync2_r;
  logic                 stable_r;
  logic [CNT_WIDTH-1:0] cnt_r;

  // Metastability guard for the asynchronous key input
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // Count consecutive disagreeing samples; adopt the new level on the last one
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r    <= {CNT_WIDTH{1'b0}};
      stable_r <= 1'b0;
    end else if (sync2_r == stable_r) begin
      cnt_r    <= {CNT_WIDTH{1'b0}};
      stable_r <= stable_r;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r    <= {CNT_WIDTH{1'b0}};
      stable_r <= sync2_r;
    end else begin
      cnt_r    <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      stable_r <= stable_r;
    end
  end

  assign stable = stable_r;

endmodule

// File: rtl/io_handshake_controller.sv
// Turns one debounced key press into exactly one confirmation or continue pulse
// per OUTPUT/INPUT/PAUSE instruction; a held key never acknowledges twice.
module io_handshake_controller
  import io_handshake_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_WIDTH       = 19
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       raw_confirm_button,
  input  logic       raw_continue_button,
  input  logic       is_input,
  input  logic       is_output,
  output logic       confirmation,
  output logic       continue_button,
  output logic       waiting,
  output logic [1:0] io_state
);

  logic      conf_stable_s;
  logic      cont_stable_s;
  logic      conf_prev_r;
  logic      cont_prev_r;
  logic      pause_req_s;
  logic      io_req_s;
  logic      req_s;
  logic      sel_stable_s;
  logic      sel_edge_s;
  io_state_e state_r;
  logic      confirmation_r;
  logic      continue_button_r;
  logic      waiting_r;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_WIDTH(CNT_WIDTH)) u_confirm_db (
    .clock  (clock),
    .reset  (reset),
    .raw    (raw_confirm_button),
    .stable (conf_stable_s)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_WIDTH(CNT_WIDTH)) u_continue_db (
    .clock  (clock),
    .reset  (reset),
    .raw    (raw_continue_button),
    .stable (cont_stable_s)
  );

  // Request decode and selection of the key that matters for this instruction
  always_comb begin
    pause_req_s  = is_input & is_output;
    io_req_s     = is_input ^ is_output;
    req_s        = pause_req_s | io_req_s;
    sel_stable_s = pause_req_s ? cont_stable_s : conf_stable_s;
    sel_edge_s   = pause_req_s ? rising(cont_stable_s, cont_prev_r)
                               : rising(conf_stable_s, conf_prev_r);
  end

  // Previous debounced levels, kept per key so switching selection cannot fake an edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      conf_prev_r <= 1'b0;
      cont_prev_r <= 1'b0;
    end else begin
      conf_prev_r <= conf_stable_s;
      cont_prev_r <= cont_stable_s;
    end
  end

  // Handshake FSM with outputs registered alongside the state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r           <= IO_IDLE;
      confirmation_r    <= 1'b0;
      continue_button_r <= 1'b0;
      waiting_r         <= 1'b0;
    end else begin
      confirmation_r    <= 1'b0;
      continue_button_r <= 1'b0;
      waiting_r         <= 1'b0;
      case (state_r)
        IO_IDLE: begin
          // arming only with the key up keeps a held key from acknowledging twice
          if (req_s && !sel_stable_s) begin
            state_r   <= IO_ARMED;
            waiting_r <= 1'b1;
          end else begin
            state_r <= IO_IDLE;
          end
        end
        IO_ARMED: begin
          if (!req_s) begin
            state_r <= IO_IDLE;
          end else if (sel_edge_s) begin
            state_r           <= IO_FIRE;
            confirmation_r    <= ~pause_req_s;
            continue_button_r <= pause_req_s;
          end else begin
            state_r   <= IO_ARMED;
            waiting_r <= 1'b1;
          end
        end
        IO_FIRE: begin
          state_r <= IO_RELEASE;
        end
        IO_RELEASE: begin
          if (!sel_stable_s) begin
            state_r <= IO_IDLE;
          end else begin
            state_r <= IO_RELEASE;
          end
        end
        default: begin
          state_r <= IO_IDLE;
        end
      endcase
    end
  end

  assign confirmation    = confirmation_r;
  assign continue_button = continue_button_r;
  assign waiting         = waiting_r;
  assign io_state        = state_r;

endmodule
